// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller and its helpers.
//   hz_state_t : controller FSM state encoding
//   REG_W_DEF  : default register index width (RV32I: 32 registers)
//   CNT_W_DEF  : default width of the stall-cycle performance counter
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-control bundle between the core datapath and the hazard controller.
//   inputs  : EX load info, ID operand indices/use flags, ME memory handshake,
//             EX branch resolution, perf counter clear
//   outputs : PC / IF-ID / ID-EX control, memory-wait freeze, stall counter
// modport master drives the pipeline status (core side), slave is the controller.
interface hazard_ctrl_unit_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             dm_rd_ex;
    logic [REG_W-1:0] rd_ex;
    logic [REG_W-1:0] rs1_de;
    logic [REG_W-1:0] rs2_de;
    logic             rs1_used_de;
    logic             rs2_used_de;
    logic             dm_req_me;
    logic             dm_ready_me;
    logic             br_taken_ex;
    logic             perf_clr;

    logic             stall_pc;
    logic             stall_fd;
    logic             bubble_de;
    logic             flush_fd;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output dm_rd_ex, rd_ex, rs1_de, rs2_de, rs1_used_de, rs2_used_de,
               dm_req_me, dm_ready_me, br_taken_ex, perf_clr,
        input  stall_pc, stall_fd, bubble_de, flush_fd, freeze, stall_cnt
    );

    modport slave (
        input  dm_rd_ex, rd_ex, rs1_de, rs2_de, rs1_used_de, rs2_used_de,
               dm_req_me, dm_ready_me, br_taken_ex, perf_clr,
        output stall_pc, stall_fd, bubble_de, flush_fd, freeze, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Combinational producer/consumer register match, shared with the forwarding unit.
//   i_rd_vld            : producer writes a register that matters (e.g. EX is a load)
//   i_rd                : producer destination index
//   i_rs1 / i_rs2       : consumer source indices
//   i_rs1_used/_used    : consumer actually reads that source
//   o_hit_c             : match on a used, non-x0 source
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic             i_rd_vld,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    output logic             o_hit_c
);

    // x0 is hardwired zero, so it never carries a real dependency
    assign o_hit_c = i_rd_vld && (i_rd != '0) &&
                     ((i_rs1_used && (i_rd == i_rs1)) ||
                      (i_rs2_used && (i_rd == i_rs2)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline, placed beside ID.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : hazard_ctrl_unit_if.slave (pipeline status in, control out)
// Priority each cycle: memory wait (freeze) > taken-branch flush > load-use stall.
// Control outputs are combinational from state/counter/inputs; stall_cnt is registered.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_unit_if.slave bus
);

    // Counter holds the remaining extra bubbles (at most LOAD_LAT-1)
    localparam int unsigned LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);

    hz_state_t        r_state;
    hz_state_t        w_eff_state;
    logic             r_ret_lu;
    logic [LAT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_hit;
    logic w_wait;
    logic w_stall_pc;
    logic w_stall_fd;
    logic w_bubble_de;
    logic w_flush_fd;
    logic w_freeze;

    hazard_match #(.REG_W(REG_W)) u_match (
        .i_rd_vld   (bus.dm_rd_ex),
        .i_rd       (bus.rd_ex),
        .i_rs1      (bus.rs1_de),
        .i_rs2      (bus.rs2_de),
        .i_rs1_used (bus.rs1_used_de),
        .i_rs2_used (bus.rs2_used_de),
        .o_hit_c    (w_hit)
    );

    assign w_wait = bus.dm_req_me && !bus.dm_ready_me;

    // MEM_WAIT only remembers where to resume; act as the saved state once the wait ends
    always_comb begin
        w_eff_state = r_state;
        if (r_state == MEM_WAIT) begin
            w_eff_state = r_ret_lu ? LU_STALL : IDLE;
        end
    end

    // Control outputs; forced low while reset is asserted
    always_comb begin
        w_stall_pc  = 1'b0;
        w_stall_fd  = 1'b0;
        w_bubble_de = 1'b0;
        w_flush_fd  = 1'b0;
        w_freeze    = 1'b0;
        if (rst_n) begin
            if (w_wait) begin
                w_freeze   = 1'b1;
                w_stall_pc = 1'b1;
                w_stall_fd = 1'b1;
            end else begin
                case (w_eff_state)
                    IDLE: begin
                        if (bus.br_taken_ex) begin
                            w_flush_fd  = 1'b1;
                            w_bubble_de = 1'b1;
                        end else if (w_hit) begin
                            w_stall_pc  = 1'b1;
                            w_stall_fd  = 1'b1;
                            w_bubble_de = 1'b1;
                        end
                    end
                    LU_STALL: begin
                        w_stall_pc  = 1'b1;
                        w_stall_fd  = 1'b1;
                        w_bubble_de = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM and latency counter; both hold while the pipeline is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ret_lu <= 1'b0;
            r_lat    <= '0;
        end else if (w_wait) begin
            if (r_state != MEM_WAIT) begin
                r_state  <= MEM_WAIT;
                r_ret_lu <= (r_state == LU_STALL);
            end
        end else begin
            case (w_eff_state)
                IDLE: begin
                    if (!bus.br_taken_ex && w_hit && (LOAD_LAT > 1)) begin
                        r_state <= LU_STALL;
                        r_lat   <= LAT_INIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LU_STALL: begin
                    if (r_lat == LAT_W'(1)) begin
                        r_state <= IDLE;
                        r_lat   <= '0;
                    end else begin
                        r_state <= LU_STALL;
                        r_lat   <= r_lat - LAT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of PC-stall cycles; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_pc  = w_stall_pc;
    assign bus.stall_fd  = w_stall_fd;
    assign bus.bubble_de = w_bubble_de;
    assign bus.flush_fd  = w_flush_fd;
    assign bus.freeze    = w_freeze;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
